// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: command front end for an SPI master.
// Host words (with a target slave ID) queue in a TX FIFO and are issued one
// at a time over the master's start/ready handshake. Each received word is
// captured into an RX FIFO that the host drains.
//
// Handshakes: the host side uses valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are 1. Valid must not depend on ready.
// rd_data is the RX head and is valid whenever rd_valid=1 (fall-through).
// The master side uses a one-cycle spi_start pulse. The master then drops
// spi_ready while it is busy and raises it again when spi_rx_data is valid.
module spi_txn_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CS       = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 64,
  localparam int SIDW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LVLW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [SIDW-1:0]       wr_slave_id,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [SIDW-1:0]       spi_slave_id,
  input  logic                  spi_ready,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic [LVLW-1:0]       tx_level,
  output logic [LVLW-1:0]       rx_level,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [2:0]            fsm_state
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int TOW  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(FIFO_DEPTH);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4
  } state_t;

  state_t state;
  logic [TOW-1:0] to_cnt;

  logic [DATA_WIDTH-1:0] tx_mem_data [FIFO_DEPTH];
  logic [SIDW-1:0]       tx_mem_id   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem      [FIFO_DEPTH];
  logic [PTRW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;

  logic sync_1, rdy_s;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic timeout_hit;

  // Host-facing flags and FIFO heads; heads read as zero when the FIFO is empty
  assign wr_ready     = (tx_level != FULL_LVL);
  assign rd_valid     = (rx_level != '0);
  assign rd_data      = rd_valid ? rx_mem[rx_rd_ptr] : '0;
  assign spi_tx_data  = (tx_level != '0) ? tx_mem_data[tx_rd_ptr] : '0;
  assign spi_slave_id = (tx_level != '0) ? tx_mem_id[tx_rd_ptr] : '0;
  assign busy         = (state != IDLE) || (tx_level != '0);
  assign fsm_state    = state;

  // Push/pop qualification; illegal pushes or pops are silently dropped
  always_comb begin
    timeout_hit = (state == WAIT_BUSY) && rdy_s && (to_cnt == TO_LAST);
    tx_push     = wr_valid && wr_ready;
    tx_pop      = (state == CAPTURE) || timeout_hit;
    rx_push     = (state == CAPTURE);
    rx_pop      = rd_valid && rd_ready;
    tx_pop_ok   = tx_pop && (tx_level != '0);
    tx_push_ok  = tx_push && ((tx_level != FULL_LVL) || tx_pop_ok);
    rx_pop_ok   = rx_pop && (rx_level != '0);
    rx_push_ok  = rx_push && ((rx_level != FULL_LVL) || rx_pop_ok);
  end

  // Two-flop synchroniser for the master's ready; idles high like the master
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      rdy_s  <= 1'b1;
    end else begin
      sync_1 <= spi_ready;
      rdy_s  <= sync_1;
    end
  end

  // FIFO storage; contents need no reset because the levels gate every read
  always_ff @(posedge clk) begin
    if (tx_push_ok) begin
      tx_mem_data[tx_wr_ptr] <= wr_data;
      tx_mem_id[tx_wr_ptr]   <= wr_slave_id;
    end
    if (rx_push_ok) begin
      rx_mem[rx_wr_ptr] <= spi_rx_data;
    end
  end

  // TX FIFO pointers and level; push and pop together leave the level alone
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + PTRW'(1);
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + PTRW'(1);
      case ({tx_push_ok, tx_pop_ok})
        2'b10:   tx_level <= tx_level + LVLW'(1);
        2'b01:   tx_level <= tx_level - LVLW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  // RX FIFO pointers and level; push and pop together leave the level alone
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PTRW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + PTRW'(1);
      case ({rx_push_ok, rx_pop_ok})
        2'b10:   rx_level <= rx_level + LVLW'(1);
        2'b01:   rx_level <= rx_level - LVLW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Transfer sequencer: launch only with RX space so the RX FIFO cannot overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spi_start   <= 1'b0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      case (state)
        IDLE: begin
          if ((tx_level != '0) && (rx_level < FULL_LVL)) begin
            state     <= LAUNCH;
            spi_start <= 1'b1;
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!rdy_s) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TOW'(1);
          end
        end
        WAIT_DONE: begin
          if (rdy_s) state <= CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a loopback SPI master model.
module tb_spi_txn_sequencer;

  localparam int DW = 8;
  localparam int SIDW = 2;
  localparam int LVLW = 4;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  logic            clk;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;
  logic [SIDW-1:0] wr_slave_id;
  logic            rd_valid;
  logic            rd_ready;
  logic [DW-1:0]   rd_data;
  logic            spi_start;
  logic [DW-1:0]   spi_tx_data;
  logic [SIDW-1:0] spi_slave_id;
  logic            spi_ready;
  logic [DW-1:0]   spi_rx_data;
  logic [LVLW-1:0] tx_level;
  logic [LVLW-1:0] rx_level;
  logic            busy;
  logic            timeout_err;
  logic [2:0]      fsm_state;

  int vectors;
  int miscompares;
  logic [DW-1:0] exp_q[$];
  logic [SIDW+DW-1:0] start_log[$];
  int n_starts;
  bit stuck;
  bit model_busy;

  spi_txn_sequencer #(
    .DATA_WIDTH(8), .NUM_CS(4), .FIFO_DEPTH(8), .BUSY_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_slave_id(wr_slave_id),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_slave_id(spi_slave_id),
    .spi_ready(spi_ready), .spi_rx_data(spi_rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
    .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Loopback master model: echoes the launched word after a short busy window
  initial begin
    logic [DW-1:0] cap;
    spi_ready = 1'b1;
    spi_rx_data = '0;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && !stuck) begin
        model_busy = 1'b1;
        n_starts++;
        start_log.push_back({spi_slave_id, spi_tx_data});
        cap = spi_tx_data;
        repeat (2) @(negedge clk);
        spi_ready = 1'b0;
        repeat (4) @(negedge clk);
        spi_rx_data = cap;
        spi_ready = 1'b1;
        model_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
    vectors++;
    if ({rd_valid, spi_start, busy, timeout_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {rd_valid, spi_start, busy, timeout_err});
    end
    vectors++;
    if ({tx_level, rx_level} !== 8'h00) begin miscompares++; $display("FAIL reset_levels: got %h want 00", {tx_level, rx_level}); end
    vectors++;
    if ({rd_data, spi_tx_data, spi_slave_id} !== 18'h0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {rd_data, spi_tx_data, spi_slave_id});
    end
    vectors++;
    if (fsm_state !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int k;
    wr_valid = 1'b1; wr_data = 8'hA5; wr_slave_id = 2'd0;
    @(negedge clk);
    wr_valid = 1'b0;
    vectors++;
    if (tx_level !== 4'd1 || spi_start !== 1'b0) begin
      miscompares++; $display("FAIL single_after_push: got level %0d start %0b want 1 0", tx_level, spi_start);
    end
    @(negedge clk);
    vectors++;
    if (spi_start !== 1'b1 || spi_tx_data !== 8'hA5 || spi_slave_id !== 2'd0) begin
      miscompares++; $display("FAIL single_launch: got start %0b data %h id %0d want 1 a5 0", spi_start, spi_tx_data, spi_slave_id);
    end
    @(negedge clk);
    vectors++;
    if (spi_start !== 1'b0) begin miscompares++; $display("FAIL single_pulse_width: got start %0b want 0", spi_start); end
    k = 0;
    while (rd_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 50) begin miscompares++; $display("FAIL single_wait: got timeout want rd_valid"); end
    vectors++;
    if (rd_data !== 8'hA5 || tx_level !== 4'd0 || rx_level !== 4'd1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_result: got data %h tx %0d rx %0d busy %0b want a5 0 1 0", rd_data, tx_level, rx_level, busy);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    vectors++;
    if (rx_level !== 4'd0 || rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_pop: got rx %0d valid %0b want 0 0", rx_level, rd_valid);
    end
  endtask

  task automatic test_fill();
    int k;
    int s0;
    s0 = n_starts;
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i); wr_slave_id = 2'd1;
      exp_q.push_back(DW'(i));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0 || tx_level !== 4'd8) begin
      miscompares++; $display("FAIL fill_full: got wr_ready %0b tx %0d want 0 8", wr_ready, tx_level);
    end
    k = 0;
    while (rx_level !== 4'd8 && k < 300) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 300) begin miscompares++; $display("FAIL fill_wait: got rx %0d want 8", rx_level); end
    vectors++;
    if (tx_level !== 4'd0 || busy !== 1'b0 || n_starts != s0 + 8) begin
      miscompares++; $display("FAIL fill_done: got tx %0d busy %0b starts %0d want 0 0 %0d", tx_level, busy, n_starts - s0, 8);
    end
    wr_valid = 1'b1; wr_data = 8'h09; wr_slave_id = 2'd1;
    exp_q.push_back(8'h09);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (n_starts != s0 + 8 || tx_level !== 4'd1 || rx_level !== 4'd8 || busy !== 1'b1) begin
      miscompares++; $display("FAIL ninth_held: got starts %0d tx %0d rx %0d busy %0b want 8 1 8 1", n_starts - s0, tx_level, rx_level, busy);
    end
    vectors++;
    if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL fill_head: got %h want %h", rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    k = 0;
    while (rx_level !== 4'd8 && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 50 || tx_level !== 4'd0 || n_starts != s0 + 9) begin
      miscompares++; $display("FAIL ninth_launch: got rx %0d tx %0d starts %0d want 8 0 9", rx_level, tx_level, n_starts - s0);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = DW'(8'h10 + i); wr_slave_id = 2'd2;
      exp_q.push_back(DW'(8'h10 + i));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    vectors++;
    if (tx_level !== 4'd8 || rx_level !== 4'd8 || wr_ready !== 1'b0 || spi_start !== 1'b0) begin
      miscompares++; $display("FAIL both_full: got tx %0d rx %0d wr_ready %0b start %0b want 8 8 0 0", tx_level, rx_level, wr_ready, spi_start);
    end
    vectors++;
    if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL both_full_head: got %h want %h", rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    k = 0;
    while (fsm_state !== S_CAPTURE && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 50 || rx_level !== 4'd7 || tx_level !== 4'd8) begin
      miscompares++; $display("FAIL capture_reach: got rx %0d tx %0d want 7 8", rx_level, tx_level);
    end
    vectors++;
    if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL capture_pop_head: got %h want %h", rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    vectors++;
    if (rx_level !== 4'd7 || tx_level !== 4'd7) begin
      miscompares++; $display("FAIL capture_pop_level: got rx %0d tx %0d want 7 7", rx_level, tx_level);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      if (rd_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
        vectors++;
        if (rd_data !== exp_q[0]) begin miscompares++; $display("FAIL stream_data: got %h want %h", rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        rd_ready = 1'b1;
      end else begin
        rd_ready = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    vectors++;
    if (k >= 2000 || tx_level !== 4'd0 || rx_level !== 4'd0) begin
      miscompares++; $display("FAIL stream_drain: got tx %0d rx %0d left %0d want 0 0 0", tx_level, rx_level, exp_q.size());
    end
  endtask

  task automatic test_multi_slave();
    int k;
    logic [SIDW+DW-1:0] want [3];
    want[0] = {2'd3, 8'h31};
    want[1] = {2'd0, 8'h32};
    want[2] = {2'd2, 8'h33};
    start_log.delete();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; {wr_slave_id, wr_data} = want[i];
      exp_q.push_back(want[i][DW-1:0]);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    k = 0;
    while ((rx_level !== 4'd3 || busy !== 1'b0) && k < 200) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 200 || start_log.size() != 3) begin
      miscompares++; $display("FAIL multi_count: got %0d starts want 3", start_log.size());
    end
    for (int i = 0; i < 3 && i < start_log.size(); i++) begin
      vectors++;
      if (start_log[i] !== want[i]) begin
        miscompares++; $display("FAIL multi_id_%0d: got %h want %h", i, start_log[i], want[i]);
      end
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        miscompares++; $display("FAIL multi_rx: got valid %0b data %h want 1 %h", rd_valid, rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      rd_ready = 1'b1;
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    stuck = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h5A; wr_slave_id = 2'd1;
    @(negedge clk);
    wr_data = 8'h6B; wr_slave_id = 2'd2;
    exp_q.push_back(8'h6B);
    @(negedge clk);
    wr_valid = 1'b0;
    k = 0;
    while (spi_start !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 10 || spi_tx_data !== 8'h5A) begin miscompares++; $display("FAIL timeout_launch: got data %h want 5a", spi_tx_data); end
    k = 0;
    while (timeout_err !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    stuck = 1'b0;
    vectors++;
    if (k != 65) begin miscompares++; $display("FAIL timeout_cycles: got %0d want 65", k); end
    vectors++;
    if (tx_level !== 4'd1 || rx_level !== 4'd0 || spi_tx_data !== 8'h6B) begin
      miscompares++; $display("FAIL timeout_drop: got tx %0d rx %0d head %h want 1 0 6b", tx_level, rx_level, spi_tx_data);
    end
    k = 0;
    while (rd_valid !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 60 || rd_data !== exp_q[0] || timeout_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout_next: got data %h err %0b want %h 1", rd_data, timeout_err, exp_q[0]);
    end
    void'(exp_q.pop_front());
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    vectors++;
    if (rx_level !== 4'd0) begin miscompares++; $display("FAIL timeout_single_rx: got rx %0d want 0", rx_level); end
  endtask

  task automatic test_reset_mid();
    int k;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DW'(8'h41 + i); wr_slave_id = 2'd1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    k = 0;
    while (fsm_state !== S_WAIT_DONE && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 50 || tx_level !== 4'd4) begin miscompares++; $display("FAIL mid_reach: got tx %0d want 4", tx_level); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_level !== 4'd0 || rx_level !== 4'd0 || busy !== 1'b0 || spi_start !== 1'b0 || wr_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset: got tx %0d rx %0d busy %0b start %0b wr_ready %0b want 0 0 0 0 1",
                              tx_level, rx_level, busy, spi_start, wr_ready);
    end
    vectors++;
    if (timeout_err !== 1'b0 || fsm_state !== S_IDLE) begin
      miscompares++; $display("FAIL mid_reset_state: got err %0b state %0d want 0 0", timeout_err, fsm_state);
    end
    rst = 1'b0;
    exp_q.delete();
    k = 0;
    while (model_busy && k < 20) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_after: got busy %0b rd_valid %0b want 0 0", busy, rd_valid);
    end
  endtask

  // Test sequence
  initial begin
    vectors = 0; miscompares = 0; n_starts = 0; stuck = 1'b0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_slave_id = '0; rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_multi_slave();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
